// File: rtl/hbm_mvm_head_scheduler.sv
// hbm_mvm_head_scheduler
// Sequences the per-head HBM MVM-after-transpose jobs of one attention layer.
// It supports grouped KV heads: R = F / W consecutive feature heads share one
// weight head. R is found by repeated subtraction, one step per cycle. Each job
// is issued over a valid/ready handshake. The next job is issued only after the
// done pulse for the current job arrives.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start             one-cycle start pulse; all cfg_* sampled on that edge
//   cfg_feature_head      number of feature heads F
//   cfg_weight_head       number of weight heads W
//   cfg_*_base/_stride    per-stream base address and per-head stride
//   busy                  high from the cycle after start until done
//   done, err             one-cycle end-of-layer pulse; err marks a bad config
//   job_valid/job_ready   job handshake to the MVM datapath
//   job_head, job_*_addr  job payload, held stable while job_valid is high
//   job_done              MVM finished the accepted job (counted only in WAIT)
module hbm_mvm_head_scheduler #(
    parameter int ADDR_W = 32,
    parameter int HEAD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [HEAD_W-1:0] cfg_feature_head,
    input  logic [HEAD_W-1:0] cfg_weight_head,
    input  logic [ADDR_W-1:0] cfg_dat_in_base,
    input  logic [ADDR_W-1:0] cfg_dat_in_head_stride,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    input  logic [ADDR_W-1:0] cfg_wt_head_stride,
    input  logic [ADDR_W-1:0] cfg_dat_out_base,
    input  logic [ADDR_W-1:0] cfg_dat_out_head_stride,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [HEAD_W-1:0] job_head,
    output logic [ADDR_W-1:0] job_dat_in_addr,
    output logic [ADDR_W-1:0] job_wt_addr,
    output logic [ADDR_W-1:0] job_dat_out_addr,
    input  logic              job_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam logic [HEAD_W-1:0] H_ZERO = {HEAD_W{1'b0}};
    localparam logic [HEAD_W-1:0] H_ONE  = {{(HEAD_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};

    state_t            state_r;
    state_t            state_nx_s;

    logic [HEAD_W-1:0] f_r;
    logic [HEAD_W-1:0] w_r;
    logic [HEAD_W-1:0] rem_r;
    logic [HEAD_W-1:0] r_r;
    logic [HEAD_W-1:0] head_r;
    logic [HEAD_W-1:0] grp_r;
    logic [ADDR_W-1:0] in_stride_r;
    logic [ADDR_W-1:0] wt_stride_r;
    logic [ADDR_W-1:0] out_stride_r;
    logic [ADDR_W-1:0] in_acc_r;
    logic [ADDR_W-1:0] wt_acc_r;
    logic [ADDR_W-1:0] out_acc_r;

    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              job_valid_r;

    logic              busy_nx_s;
    logic              done_nx_s;
    logic              err_nx_s;
    logic              job_valid_nx_s;

    logic              sub_step_s;
    logic              cfg_bad_s;
    logic              last_head_s;
    logic              grp_wrap_s;
    logic              handshake_s;

    // Decode helpers for the SETUP, ISSUE and NEXT decisions.
    always_comb begin
        sub_step_s  = (w_r != H_ZERO) && (rem_r >= w_r);
        cfg_bad_s   = (w_r == H_ZERO) || (f_r == H_ZERO) || (rem_r != H_ZERO);
        last_head_s = (head_r == (f_r - H_ONE));
        grp_wrap_s  = ((grp_r + H_ONE) == r_r);
        handshake_s = job_valid_r && job_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) state_nx_s = ST_SETUP;
                else           state_nx_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (sub_step_s)     state_nx_s = ST_SETUP;
                else if (cfg_bad_s) state_nx_s = ST_FINISH;
                else                state_nx_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (handshake_s) state_nx_s = ST_WAIT;
                else             state_nx_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (job_done) state_nx_s = ST_NEXT;
                else          state_nx_s = ST_WAIT;
            end
            ST_NEXT: begin
                if (last_head_s) state_nx_s = ST_FINISH;
                else             state_nx_s = ST_ISSUE;
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so that the status outputs are registered.
    // FINISH is entered from SETUP only on a bad config, which gives err.
    always_comb begin
        busy_nx_s      = 1'b0;
        done_nx_s      = 1'b0;
        err_nx_s       = 1'b0;
        job_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_SETUP, ST_WAIT, ST_NEXT: begin
                busy_nx_s = 1'b1;
            end
            ST_ISSUE: begin
                busy_nx_s      = 1'b1;
                job_valid_nx_s = 1'b1;
            end
            ST_FINISH: begin
                done_nx_s = 1'b1;
                err_nx_s  = (state_r == ST_SETUP);
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            job_valid_r <= 1'b0;
        end else begin
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            err_r       <= err_nx_s;
            job_valid_r <= job_valid_nx_s;
        end
    end

    // Config latch, group-size search, and per-head address accumulators.
    // The accumulators are loaded on start. They change only in NEXT, so the
    // payload stays stable for the whole time job_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_r          <= H_ZERO;
            w_r          <= H_ZERO;
            rem_r        <= H_ZERO;
            r_r          <= H_ZERO;
            head_r       <= H_ZERO;
            grp_r        <= H_ZERO;
            in_stride_r  <= A_ZERO;
            wt_stride_r  <= A_ZERO;
            out_stride_r <= A_ZERO;
            in_acc_r     <= A_ZERO;
            wt_acc_r     <= A_ZERO;
            out_acc_r    <= A_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        f_r          <= cfg_feature_head;
                        w_r          <= cfg_weight_head;
                        rem_r        <= cfg_feature_head;
                        r_r          <= H_ZERO;
                        head_r       <= H_ZERO;
                        grp_r        <= H_ZERO;
                        in_stride_r  <= cfg_dat_in_head_stride;
                        wt_stride_r  <= cfg_wt_head_stride;
                        out_stride_r <= cfg_dat_out_head_stride;
                        in_acc_r     <= cfg_dat_in_base;
                        wt_acc_r     <= cfg_wt_base;
                        out_acc_r    <= cfg_dat_out_base;
                    end
                end
                ST_SETUP: begin
                    if (sub_step_s) begin
                        rem_r <= rem_r - w_r;
                        r_r   <= r_r + H_ONE;
                    end
                end
                ST_NEXT: begin
                    head_r    <= head_r + H_ONE;
                    in_acc_r  <= in_acc_r + in_stride_r;
                    out_acc_r <= out_acc_r + out_stride_r;
                    if (grp_wrap_s) begin
                        grp_r    <= H_ZERO;
                        wt_acc_r <= wt_acc_r + wt_stride_r;
                    end else begin
                        grp_r    <= grp_r + H_ONE;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;
    assign job_valid        = job_valid_r;
    assign job_head         = head_r;
    assign job_dat_in_addr  = in_acc_r;
    assign job_wt_addr      = wt_acc_r;
    assign job_dat_out_addr = out_acc_r;

endmodule

// File: doc/hbm_mvm_head_scheduler.md
Name: hbm_mvm_head_scheduler

Overview:
- Sequences the per-head HBM MVM-after-transpose jobs of an attention layer: one job per feature head.
- Supports grouped KV heads: R = Feature_Head / Weight_Head consecutive feature heads share one weight head.
- Latches a layer config on start, derives per-head data-in, weight and data-out addresses from base plus head stride, and issues each job to the MVM datapath over a valid/ready handshake.
- Waits for each job's done pulse before issuing the next job, and reports layer completion or a config error.

Parameters:
ADDR_W, 32, HBM byte-address width
HEAD_W, 8, width of head counts and head index

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_start  in  1  one-cycle start pulse; config sampled on the same edge
cfg_feature_head  in  HEAD_W  number of feature heads F
cfg_weight_head  in  HEAD_W  number of weight heads W
cfg_dat_in_base  in  ADDR_W  data-in base address
cfg_dat_in_head_stride  in  ADDR_W  data-in per-head stride
cfg_wt_base  in  ADDR_W  weight base address
cfg_wt_head_stride  in  ADDR_W  weight per-head stride
cfg_dat_out_base  in  ADDR_W  data-out base address
cfg_dat_out_head_stride  in  ADDR_W  data-out per-head stride
busy  out  1  high from the cycle after cfg_start accepted until done
done  out  1  one-cycle pulse at end of layer (also on error)
err  out  1  one-cycle pulse with done when config is invalid
job_valid  out  1  job request to MVM
job_ready  in  1  MVM accepts job
job_head  out  HEAD_W  feature head index of current job
job_dat_in_addr  out  ADDR_W  data-in address for job
job_wt_addr  out  ADDR_W  weight address for job
job_dat_out_addr  out  ADDR_W  data-out address for job
job_done  in  1  one-cycle pulse, MVM finished accepted job

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters and accumulators 0. Reset mid-layer aborts immediately with no done pulse.
- FSM states and transitions:
  - IDLE: cfg_start latches all cfg_*, sets rem=F and R=0, then goes to SETUP. cfg_start in any other state is ignored.
  - SETUP computes R by repeated subtraction, one step per cycle:
    - if W!=0 and rem>=W: rem-=W, R++.
    - else if W==0, F==0 or rem!=0: go to FINISH with error.
    - else: load accumulators to the bases, head=0, grp=0, go to ISSUE.
    - SETUP lasts R+1 cycles.
  - ISSUE: job_valid=1 with payload registered and stable while job_valid is high. On job_valid&&job_ready, go to WAIT and drop job_valid the next cycle.
  - WAIT: job_done goes to NEXT. job_done outside WAIT is ignored.
  - NEXT, one cycle:
    - head++; dat_in_addr+=in_stride; dat_out_addr+=out_stride; grp++.
    - if grp reaches R: grp=0 and wt_addr+=wt_stride.
    - if head==F-1 before the increment: go to FINISH, else go to ISSUE.
  - FINISH: done=1 (err=1 if error) for one cycle, busy falls the same cycle, then IDLE.
- Timing: with cfg_start sampled at edge k, busy=1 from k+1 and first job_valid=1 at cycle k+R+2.
- Minimum spacing between consecutive job_valid assertions is 2 cycles after job_done (NEXT state, then ISSUE).
- Address arithmetic is unsigned and wraps modulo 2^ADDR_W; no overflow flag. Job for head h carries:
  - dat_in = base_in + h*in_stride
  - wt = base_wt + floor(h/R)*wt_stride
  - dat_out = base_out + h*out_stride
- A job_done arriving in the same cycle as the handshake is not counted; only WAIT-state job_done counts.
- Config inputs are don't-care after cfg_start is sampled.

Test Plan:
- F=32, W=2, bases 11307008/12355584/12421120, strides in=4096, wt=8192, out=4096, job_ready tied 1, job_done 3 cycles after accept:
  - exactly 32 jobs with job_head 0..31.
  - head 15: dat_in=11368448, wt=12355584.
  - head 16: wt=12363776.
  - head 31: dat_out=12548096.
  - first job_valid at start+18; one done pulse, err=0.
- Same config with job_ready low for 5 cycles per job -> payload stable while job_valid is high, no job lost or duplicated, 32 jobs total.
- F=5, W=2 -> no job_valid; done=err=1 pulse 4 cycles after start. F=4, W=0 -> done=err=1 with no job issued.
- F=W=1 -> single job with base addresses; done pulse 2 cycles after job_done.
- Stray job_done in ISSUE and cfg_start while busy -> ignored, job count unchanged, no restart.
- rst_n low during WAIT of head 7 -> all outputs 0 asynchronously; a subsequent start runs a full layer from head 0.
